// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N-to-1 multiplexer with valid/ready on every input
// and on the output. MODE=0 arbitrates round-robin among valid inputs,
// MODE=1 forwards only the channel named by SEL. One-entry output register,
// one-cycle latency, full throughput when the consumer is always ready.
module rr_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MODE,
  input  logic [SEL_W-1:0]   SEL,
  input  logic [N-1:0]       IN_VALID,
  input  logic [N*WIDTH-1:0] IN_DATA,
  output logic [N-1:0]       IN_READY,
  output logic               OUT_VALID,
  output logic [WIDTH-1:0]   OUT_DATA,
  output logic [SEL_W-1:0]   OUT_SRC,
  input  logic               OUT_READY
);

  logic [SEL_W-1:0] ptr;
  logic             load;
  logic             xfer;
  logic             found;
  logic [SEL_W-1:0] gidx;
  logic             hi_found;
  logic             lo_found;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic [WIDTH-1:0] gdata;

  // The register takes a new word when empty or being drained this cycle.
  assign load = !OUT_VALID || OUT_READY;
  assign xfer = found && load;

  // Grant search. Round-robin is split into two priority scans: the lowest
  // valid index at or above ptr wins, otherwise the lowest valid index
  // overall, which is the wrap-around part of the circular search.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    found    = 1'b0;
    gidx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (IN_VALID[i]) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
        if (SEL_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end
      end
    end
    if (MODE) begin
      // An out-of-range SEL matches no channel, so it never grants.
      for (int i = 0; i < N; i++) begin
        if (SEL == SEL_W'(i) && IN_VALID[i]) begin
          found = 1'b1;
          gidx  = SEL_W'(i);
        end
      end
    end else begin
      found = lo_found;
      gidx  = hi_found ? hi_idx : lo_idx;
    end
  end

  // Decode the winner into the ready vector and select its data word.
  // Ready is held low while reset is asserted.
  always_comb begin
    IN_READY = '0;
    gdata    = '0;
    for (int i = 0; i < N; i++) begin
      if (gidx == SEL_W'(i)) begin
        gdata       = IN_DATA[i*WIDTH +: WIDTH];
        IN_READY[i] = found && load && RST;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_SRC   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= gdata;
      OUT_SRC   <= gidx;
      if (!MODE) begin
        ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
      end
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: vector table, hand-written corner sequences and
// random traffic against a circular-search reference model. A second
// instance with N=3 covers the non-power-of-two select range.
module tb_rr_mux_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  logic         t3_mode;
  logic [1:0]   t3_sel;
  logic [2:0]   t3_in_valid;
  logic [23:0]  t3_in_data;
  logic [2:0]   t3_in_ready;
  logic         t3_out_valid;
  logic [7:0]   t3_out_data;
  logic [1:0]   t3_out_src;
  logic         t3_out_ready;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state for the N=4 instance.
  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_ptr;

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(32), .N(4), .SEL_W(2)) dut (
    .CLK(clk), .RST(rst_n), .MODE(mode), .SEL(sel),
    .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
    .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_SRC(out_src),
    .OUT_READY(out_ready)
  );

  rr_mux_reg #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
    .CLK(clk), .RST(rst_n), .MODE(t3_mode), .SEL(t3_sel),
    .IN_VALID(t3_in_valid), .IN_DATA(t3_in_data), .IN_READY(t3_in_ready),
    .OUT_VALID(t3_out_valid), .OUT_DATA(t3_out_data), .OUT_SRC(t3_out_src),
    .OUT_READY(t3_out_ready)
  );

  typedef struct {
    bit         mode;
    logic [1:0] sel;
    logic [3:0] valid;
    bit         ordy;
    logic [3:0] exp_rdy;
    bit         exp_ov;
    int         exp_src;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Grant by the circular-search rule; -1 means no grant.
  function automatic int model_grant(bit md, int s, logic [15:0] v, int p, int n);
    if (md) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (p + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  // Called a few ns after the inputs settle; crosses one rising edge.
  task automatic cycle4(input string tag);
    int         g;
    bit         ld;
    logic [3:0] exp_rdy;
    ld = !m_valid || out_ready;
    g  = model_grant(mode, int'(sel), {12'b0, in_valid}, m_ptr, 4);
    exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
    chk({tag, ":in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (ld && g >= 0) begin
      m_valid = 1;
      m_data  = in_data[g*32 +: 32];
      m_src   = g;
      if (!mode) m_ptr = (g + 1) % 4;
    end else if (out_ready && m_valid) begin
      m_valid = 0;
    end
    #1;
    chk({tag, ":out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ":out_data"}, 64'(out_data), 64'(m_data));
    chk({tag, ":out_src"}, 64'(out_src), 64'(m_src));
  endtask

  task automatic step4(input string tag);
    #2;
    cycle4(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 2'd0, 4'b1111, 1, 4'b0001, 1, 0};
    tbl[1]  = '{0, 2'd0, 4'b1111, 1, 4'b0010, 1, 1};
    tbl[2]  = '{0, 2'd0, 4'b1111, 1, 4'b0100, 1, 2};
    tbl[3]  = '{0, 2'd0, 4'b1111, 1, 4'b1000, 1, 3};
    tbl[4]  = '{0, 2'd0, 4'b1111, 1, 4'b0001, 1, 0};
    tbl[5]  = '{0, 2'd0, 4'b1111, 1, 4'b0010, 1, 1};
    tbl[6]  = '{0, 2'd0, 4'b1010, 1, 4'b1000, 1, 3};
    tbl[7]  = '{0, 2'd0, 4'b1010, 1, 4'b0010, 1, 1};
    tbl[8]  = '{0, 2'd0, 4'b1010, 1, 4'b1000, 1, 3};
    tbl[9]  = '{0, 2'd0, 4'b0000, 1, 4'b0000, 0, 3};
    tbl[10] = '{0, 2'd0, 4'b0001, 0, 4'b0001, 1, 0};
    tbl[11] = '{0, 2'd0, 4'b1111, 0, 4'b0000, 1, 0};
    tbl[12] = '{0, 2'd0, 4'b1111, 1, 4'b0010, 1, 1};
    tbl[13] = '{1, 2'd2, 4'b1111, 1, 4'b0100, 1, 2};
    tbl[14] = '{1, 2'd2, 4'b1111, 1, 4'b0100, 1, 2};
    tbl[15] = '{1, 2'd2, 4'b1011, 1, 4'b0000, 0, 2};
    tbl[16] = '{0, 2'd0, 4'b1111, 1, 4'b0100, 1, 2};
    tbl[17] = '{1, 2'd0, 4'b0001, 0, 4'b0000, 1, 2};
    tbl[18] = '{1, 2'd0, 4'b0001, 1, 4'b0001, 1, 0};

    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    t3_mode = 1'b0; t3_sel = '0; t3_in_valid = '0; t3_in_data = '0; t3_out_ready = 1'b1;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset:out_valid", 64'(out_valid), 64'd0);
    chk("reset:out_data", 64'(out_data), 64'd0);
    chk("reset:out_src", 64'(out_src), 64'd0);
    in_valid = 4'b1111;
    #1;
    chk("reset:in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;

    // Vector table, channel i carries 0xA0+i.
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 19; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].valid; out_ready = tbl[i].ordy;
      #2;
      chk($sformatf("tbl%0d:in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      cycle4($sformatf("tbl%0d:model", i));
      chk($sformatf("tbl%0d:out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d:out_src", i), 64'(out_src), 64'(tbl[i].exp_src));
      chk($sformatf("tbl%0d:out_data", i), 64'(out_data), 64'(32'hA0 + tbl[i].exp_src));
    end

    // Backpressure holds the word from channel 2 for five cycles.
    mode = 1'b1; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data[2*32 +: 32] = 32'hDEADBEEF;
    step4("bp_load");
    out_ready = 1'b0; mode = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step4($sformatf("bp_hold%0d", i));
      chk($sformatf("bp_hold%0d:data", i), 64'(out_data), 64'h0000_0000_DEAD_BEEF);
      chk($sformatf("bp_hold%0d:src", i), 64'(out_src), 64'd2);
    end
    out_ready = 1'b1;
    #2;
    chk("bp_release:ready_any", 64'(in_ready != 4'b0), 64'd1);
    cycle4("bp_release");
    chk("bp_release:no_bubble", 64'(out_valid), 64'd1);

    // Reset mid-cycle while the register is full and stalled.
    out_ready = 1'b0;
    step4("pre_rst");
    #4;
    rst_n = 1'b0;
    #1;
    chk("midrst:out_valid", 64'(out_valid), 64'd0);
    chk("midrst:out_data", 64'(out_data), 64'd0);
    chk("midrst:out_src", 64'(out_src), 64'd0);
    chk("midrst:in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    step4("post_rst");
    chk("post_rst:first_grant", 64'(out_src), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      mode      = ($urandom_range(0, 3) == 0);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      step4($sformatf("rnd%0d", i));
    end

    // N=3: SEL=3 never grants; round-robin wraps 2 -> 0.
    t3_mode = 1'b1; t3_sel = 2'd3; t3_in_valid = 3'b111; t3_out_ready = 1'b1;
    t3_in_data = {8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 4; i++) begin
      #3;
      chk($sformatf("n3_sel3_%0d:in_ready", i), 64'(t3_in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("n3_sel3_%0d:out_valid", i), 64'(t3_out_valid), 64'd0);
    end
    t3_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk($sformatf("n3_rr%0d:in_ready", i), 64'(t3_in_ready), 64'(1 << (i % 3)));
      @(posedge clk);
      #1;
      chk($sformatf("n3_rr%0d:out_src", i), 64'(t3_out_src), 64'(i % 3));
      chk($sformatf("n3_rr%0d:out_data", i), 64'(t3_out_data), 64'(8'h10 + (i % 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
